ex_mem_skid_reg: RTL and testbench

//  EX->MEM pipeline stage register that sits directly downstream of the ALU.
//  - Captures the ALU result, store data, destination register and memory/writeback

---
 rtl/ex_mem_skid_reg.sv | 85 ++++++++
 tb/tb_ex_mem_skid_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM stage register with a 2-entry skid buffer and branch resolve.
// Optional perf counters are built when EX_MEM_PERF_EN is defined; otherwise the ports read 0.
module ex_mem_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  input  logic [DATA_WIDTH-1:0] BrTarget,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  Branch,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] m_ALUResult,
  output logic [DATA_WIDTH-1:0] m_StoreData,
  output logic [REG_ADDR_W-1:0] m_rd,
  output logic                  m_MemRead,
  output logic                  m_MemWrite,
  output logic                  m_RegWrite,
  output logic                  m_MemtoReg,
  output logic                  m_BrTaken,
  output logic [DATA_WIDTH-1:0] m_BrTarget,
  output logic [CNT_WIDTH-1:0]  perf_retired,
  output logic [CNT_WIDTH-1:0]  perf_stall
);
  localparam int BW = 3*DATA_WIDTH + REG_ADDR_W + 5;
  logic [BW-1:0] w_in, r_h, r_s;
  logic          r_hv, r_sv, w_acc, w_con, w_br;
  assign w_in      = {ALUResult, StoreData, BrTarget, rd, Branch, MemRead, MemWrite, RegWrite, MemtoReg};
  assign {m_ALUResult, m_StoreData, m_BrTarget, m_rd, w_br, m_MemRead, m_MemWrite, m_RegWrite, m_MemtoReg} = r_h;
  assign m_BrTaken = w_br & m_ALUResult[0];
  assign out_valid = r_hv;
  assign in_ready  = !r_sv;
  assign w_acc     = in_valid & !r_sv;
  assign w_con     = r_hv & out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hv <= 1'b0;
      r_sv <= 1'b0;
      r_h  <= '0;
      r_s  <= '0;
    end else if (flush) begin
      r_hv <= 1'b0;
      r_sv <= 1'b0;
    end else if (r_sv) begin
      if (w_con) begin
        r_h  <= r_s;
        r_sv <= 1'b0;
      end
    end else if (!r_hv || w_con) begin
      r_hv <= w_acc;
      if (w_acc) r_h <= w_in;
    end else if (w_acc) begin
      r_s  <= w_in;
      r_sv <= 1'b1;
    end
  end
`ifdef EX_MEM_PERF_EN
  logic [CNT_WIDTH-1:0] r_ret, r_stall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret   <= '0;
      r_stall <= '0;
    end else begin
      if (w_con) r_ret <= r_ret + 1'b1;
      if (r_hv && !out_ready) r_stall <= r_stall + 1'b1;
    end
  end
  assign perf_retired = r_ret;
  assign perf_stall   = r_stall;
`else
  assign perf_retired = '0;
  assign perf_stall   = '0;
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: queue-based model checked every cycle plus directed literal checks.
module tb_ex_mem_skid_reg;
  typedef struct packed {
    logic [31:0] alu, sd, tgt;
    logic [4:0]  rd;
    logic        br, mr, mw, rw, m2r;
  } beat_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] ALUResult = 0, StoreData = 0, BrTarget = 0, m_ALUResult, m_StoreData, m_BrTarget;
  logic [4:0]  rd = 0, m_rd;
  logic Branch = 0, MemRead = 0, MemWrite = 0, RegWrite = 0, MemtoReg = 0;
  logic m_MemRead, m_MemWrite, m_RegWrite, m_MemtoReg, m_BrTaken;
  logic [15:0] perf_retired, perf_stall;
  int n_cmp = 0, n_bad = 0;
  beat_t q[$];
  beat_t last_head = '0;
  int unsigned exp_ret = 0, exp_stall = 0;
  logic [31:0] seen[$];

  ex_mem_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .BrTarget(BrTarget), .rd(rd),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .out_valid(out_valid), .out_ready(out_ready),
    .m_ALUResult(m_ALUResult), .m_StoreData(m_StoreData), .m_rd(m_rd),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .m_RegWrite(m_RegWrite),
    .m_MemtoReg(m_MemtoReg), .m_BrTaken(m_BrTaken), .m_BrTarget(m_BrTarget),
    .perf_retired(perf_retired), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two beats; the head's fields are shown, held when empty.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_head = '0;
      exp_ret   = 0;
      exp_stall = 0;
    end else begin
      automatic bit acc = in_valid && q.size() < 2;
      automatic bit con = q.size() > 0 && out_ready;
      if (con) exp_ret = (exp_ret + 1) % 65536;
      if (q.size() > 0 && !out_ready) exp_stall = (exp_stall + 1) % 65536;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back('{ALUResult, StoreData, BrTarget, rd, Branch, MemRead, MemWrite, RegWrite, MemtoReg});
      end
      if (q.size() > 0) last_head = q[0];
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("m_ALUResult", m_ALUResult, last_head.alu);
    check("m_StoreData", m_StoreData, last_head.sd);
    check("m_BrTarget", m_BrTarget, last_head.tgt);
    check("m_rd", m_rd, last_head.rd);
    check("m_ctrl", {m_MemRead, m_MemWrite, m_RegWrite, m_MemtoReg},
          {last_head.mr, last_head.mw, last_head.rw, last_head.m2r});
    check("m_BrTaken", m_BrTaken, last_head.br & last_head.alu[0]);
`ifdef EX_MEM_PERF_EN
    check("perf_retired", perf_retired, exp_ret);
    check("perf_stall", perf_stall, exp_stall);
`else
    check("perf_retired", perf_retired, 0);
    check("perf_stall", perf_stall, 0);
`endif
    if (out_valid && out_ready) seen.push_back(m_ALUResult);
  end

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] tgt,
                        input logic br, input logic [4:0] r);
    in_valid = v; ALUResult = alu; StoreData = alu ^ 32'hA5A5_0000; BrTarget = tgt;
    Branch = br; rd = r; MemRead = alu[1]; MemWrite = alu[2]; RegWrite = alu[3]; MemtoReg = alu[4];
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_seen(input string name, input logic [31:0] exp[$]);
    check({name, "_count"}, seen.size(), exp.size());
    foreach (exp[i]) check(name, (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  initial begin
    set_in(1, 7, 0, 0, 3);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_m_alu", m_ALUResult, 0);
    check("rst_m_rd", m_rd, 0);
    reset = 0;
    step(1);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("first_valid", out_valid, 1);
    check("first_alu", m_ALUResult, 7);
    check("first_rd", m_rd, 3);
    step(1);
    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      set_in(1, i, 0, 0, 5'(i));
      step(1);
    end
    set_in(0, 0, 0, 0, 0);
    step(3);
    check_seen("stream", '{1, 2, 3, 4, 5, 6, 7, 8});
    out_ready = 0;
    seen.delete();
    set_in(1, 32'h10, 0, 0, 1); step(1);
    set_in(1, 32'h20, 0, 0, 2); step(1);
    set_in(1, 32'h30, 0, 0, 3); step(2);
    check("skid_in_ready", in_ready, 0);
    check("skid_head", m_ALUResult, 32'h10);
    out_ready = 1;
    step(2);
    set_in(0, 0, 0, 0, 0);
    step(3);
    check_seen("skid", '{32'h10, 32'h20, 32'h30});
    set_in(1, 1, 32'h40, 1, 0); step(1); set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("br_taken", m_BrTaken, 1);
    check("br_target", m_BrTarget, 32'h40);
    step(1);
    set_in(1, 0, 32'h44, 1, 0); step(1); set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("br_not_eq", m_BrTaken, 0);
    step(1);
    set_in(1, 1, 32'h48, 0, 0); step(1); set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("br_nobranch", m_BrTaken, 0);
    step(1);
    out_ready = 0;
    set_in(1, 32'h11, 0, 0, 1); step(1);
    set_in(1, 32'h22, 0, 0, 2); step(1);
    set_in(1, 32'h99, 0, 0, 9); flush = 1; step(1);
    flush = 0; set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1;
    seen.delete();
    step(4);
    check("flush_drop", seen.size(), 0);
    out_ready = 0;
    set_in(1, 32'h55, 0, 0, 5); step(1);
    set_in(1, 32'h66, 0, 0, 6); step(1);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_ready", in_ready, 1);
    check("async_alu", m_ALUResult, 0);
    check("async_retired", perf_retired, 0);
    @(negedge clk);
    reset = 0;
    set_in(1, 32'h70, 0, 0, 7); step(1);
    set_in(0, 0, 0, 0, 0); step(3);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h71 + i, 0, 0, 1);
      step(1);
    end
    set_in(0, 0, 0, 0, 0);
    step(1);
    @(negedge clk);
`ifdef EX_MEM_PERF_EN
    check("perf_stall_lit", perf_stall, 3);
    check("perf_retired_lit", perf_retired, 5);
`else
    check("perf_stall_off", perf_stall, 0);
    check("perf_retired_off", perf_retired, 0);
`endif
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
